// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: prioritises requests and runs flush, commit, redirect.
// Optional TRAP_CTRL_IRQ_SYNC_EN adds 2-flop synchronisers on the three interrupt inputs.
module trap_ctrl #(
    parameter int unsigned FLUSH_TIMEOUT = 16,
    parameter int unsigned CAUSE_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               irq_msip,
    input  logic               irq_mtip,
    input  logic               irq_meip,
    input  logic               csr_mstatus_mie,
    input  logic [31:0]        csr_mie,
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_code,
    input  logic [31:0]        exc_tval,
    input  logic [31:0]        pipe_pc,
    input  logic               mret_req,
    input  logic               wfi_req,
    input  logic               flush_ack,
    output logic               flush_req,
    output logic               stall,
    output logic               trap_commit,
    output logic               trap_is_interrupt,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [31:0]        trap_epc,
    output logic [31:0]        trap_tval,
    output logic               mret_commit,
    output logic               pc_redirect_valid,
    output logic [31:0]        mip_out,
    output logic               timeout_err
);

    localparam int unsigned CntW = $clog2(FLUSH_TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(FLUSH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StCommit,
        StRedirect,
        StWait
    } state_e;

    state_e state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_mret_q, is_mret_d;
    logic               is_int_q, is_int_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        tval_q, tval_d;
    logic               timeout_q, timeout_d;
    logic               flush_req_q, flush_req_d;
    logic               stall_q, stall_d;
    logic               trap_commit_q, trap_commit_d;
    logic               mret_commit_q, mret_commit_d;
    logic               redirect_q, redirect_d;

    logic [2:0] irq_raw;
    logic [2:0] irq_s;
    assign irq_raw = {irq_meip, irq_mtip, irq_msip};

`ifdef TRAP_CTRL_IRQ_SYNC_EN
    logic [2:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_raw;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = irq_raw;
`endif

    assign mip_out = {20'b0, irq_s[2], 3'b0, irq_s[1], 3'b0, irq_s[0], 3'b0};

    logic [31:0]        pend;
    logic               pend_any;
    logic               irq_take;
    logic [CAUSE_W-1:0] irq_cause;

    assign pend     = mip_out & csr_mie;
    assign pend_any = |pend;
    assign irq_take = csr_mstatus_mie & pend_any;

    // Machine priority order is MEI > MSI > MTI, not numeric cause order.
    always_comb begin
        irq_cause = CAUSE_W'(7);
        if (pend[11]) begin
            irq_cause = CAUSE_W'(11);
        end else if (pend[3]) begin
            irq_cause = CAUSE_W'(3);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mret_d = is_mret_q;
        is_int_d  = is_int_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        tval_d    = tval_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (exc_valid) begin
                    is_mret_d = 1'b0;
                    is_int_d  = 1'b0;
                    cause_d   = exc_code;
                    epc_d     = pipe_pc;
                    tval_d    = exc_tval;
                    cnt_d     = '0;
                    state_d   = StFlush;
                end else if (irq_take) begin
                    is_mret_d = 1'b0;
                    is_int_d  = 1'b1;
                    cause_d   = irq_cause;
                    epc_d     = pipe_pc;
                    tval_d    = '0;
                    cnt_d     = '0;
                    state_d   = StFlush;
                end else if (mret_req) begin
                    is_mret_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StFlush;
                end else if (wfi_req && !pend_any) begin
                    state_d = StWait;
                end
            end
            StFlush: begin
                if (flush_ack) begin
                    state_d = StCommit;
                end else if (cnt_q == CntMax) begin
                    timeout_d = 1'b1;
                    state_d   = StCommit;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCommit: begin
                state_d = StRedirect;
            end
            StRedirect: begin
                state_d = StIdle;
            end
            StWait: begin
                // Any enabled pending source wakes the hart; it traps only if MIE allows.
                if (pend_any) begin
                    if (csr_mstatus_mie) begin
                        is_mret_d = 1'b0;
                        is_int_d  = 1'b1;
                        cause_d   = irq_cause;
                        epc_d     = pipe_pc;
                        tval_d    = '0;
                        cnt_d     = '0;
                        state_d   = StFlush;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered by decoding the next state.
    always_comb begin
        flush_req_d   = (state_d == StFlush);
        stall_d       = (state_d != StIdle);
        trap_commit_d = (state_d == StCommit) && !is_mret_d;
        mret_commit_d = (state_d == StCommit) && is_mret_d;
        redirect_d    = (state_d == StRedirect);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            is_mret_q     <= 1'b0;
            is_int_q      <= 1'b0;
            cause_q       <= '0;
            epc_q         <= '0;
            tval_q        <= '0;
            timeout_q     <= 1'b0;
            flush_req_q   <= 1'b0;
            stall_q       <= 1'b0;
            trap_commit_q <= 1'b0;
            mret_commit_q <= 1'b0;
            redirect_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_mret_q     <= is_mret_d;
            is_int_q      <= is_int_d;
            cause_q       <= cause_d;
            epc_q         <= epc_d;
            tval_q        <= tval_d;
            timeout_q     <= timeout_d;
            flush_req_q   <= flush_req_d;
            stall_q       <= stall_d;
            trap_commit_q <= trap_commit_d;
            mret_commit_q <= mret_commit_d;
            redirect_q    <= redirect_d;
        end
    end

    assign flush_req         = flush_req_q;
    assign stall             = stall_q;
    assign trap_commit       = trap_commit_q;
    assign mret_commit       = mret_commit_q;
    assign pc_redirect_valid = redirect_q;
    assign trap_is_interrupt = is_int_q;
    assign trap_cause        = cause_q;
    assign trap_epc          = epc_q;
    assign trap_tval         = tval_q;
    assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, WFI/reset sequences, random transactions.
module tb_trap_ctrl;

    localparam int T  = 16;
    localparam int CW = 5;

    localparam int KNone = 0;
    localparam int KTrap = 1;
    localparam int KMret = 2;
    localparam int KWait = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          irq_msip = 1'b0, irq_mtip = 1'b0, irq_meip = 1'b0;
    logic          csr_mstatus_mie = 1'b0;
    logic [31:0]   csr_mie = '0;
    logic          exc_valid = 1'b0;
    logic [CW-1:0] exc_code = '0;
    logic [31:0]   exc_tval = '0;
    logic [31:0]   pipe_pc = '0;
    logic          mret_req = 1'b0, wfi_req = 1'b0, flush_ack = 1'b0;
    logic          flush_req, stall, trap_commit, trap_is_interrupt;
    logic [CW-1:0] trap_cause;
    logic [31:0]   trap_epc, trap_tval, mip_out;
    logic          mret_commit, pc_redirect_valid, timeout_err;

    trap_ctrl #(.FLUSH_TIMEOUT(T), .CAUSE_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
        .pipe_pc(pipe_pc), .mret_req(mret_req), .wfi_req(wfi_req),
        .flush_ack(flush_ack), .flush_req(flush_req), .stall(stall),
        .trap_commit(trap_commit), .trap_is_interrupt(trap_is_interrupt),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .mret_commit(mret_commit), .pc_redirect_valid(pc_redirect_valid),
        .mip_out(mip_out), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          exc;
        logic [CW-1:0] code;
        logic [31:0]   tval;
        logic [31:0]   pc;
        logic [2:0]    irq;   // {meip, mtip, msip}
        logic [31:0]   mie;
        logic          gmie;
        logic          mret;
        logic          wfi;
        int            delay;
        int            kind;
        logic [CW-1:0] cause;
        logic          is_int;
        logic [31:0]   etval;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int tag = 0;
    logic err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL [%0d] %s: got %h, expected %h", tag, name, got, exp);
        end
    endtask

    function automatic logic [31:0] mip_of(input logic [2:0] irq);
        return (32'(irq[2]) << 11) | (32'(irq[1]) << 7) | (32'(irq[0]) << 3);
    endfunction

    function automatic logic [CW-1:0] prio(input logic [31:0] pend);
        int order [3] = '{11, 3, 7};
        for (int i = 0; i < 3; i++) begin
            if (pend[order[i]]) return CW'(order[i]);
        end
        return '0;
    endfunction

    // Reference decision for one request presented in IDLE.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [31:0] pend = mip_of(v.irq) & v.mie;
        r.cause = '0; r.is_int = 1'b0; r.etval = '0;
        if (v.exc) begin
            r.kind = KTrap; r.cause = v.code; r.etval = v.tval;
        end else if (v.gmie && pend != 0) begin
            r.kind = KTrap; r.cause = prio(pend); r.is_int = 1'b1;
        end else if (v.mret) begin
            r.kind = KMret;
        end else if (v.wfi) begin
            r.kind = (pend == 0) ? KWait : KNone;
        end else begin
            r.kind = KNone;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic exc, input logic [CW-1:0] code, input logic [31:0] tval,
                                input logic [31:0] pc, input logic [2:0] irq,
                                input logic [31:0] mie, input logic gmie, input logic mret,
                                input logic wfi, input int delay, input int kind,
                                input logic [CW-1:0] cause, input logic is_int,
                                input logic [31:0] etval);
        vec_t v;
        v.exc = exc; v.code = code; v.tval = tval; v.pc = pc; v.irq = irq; v.mie = mie;
        v.gmie = gmie; v.mret = mret; v.wfi = wfi; v.delay = delay; v.kind = kind;
        v.cause = cause; v.is_int = is_int; v.etval = etval;
        return v;
    endfunction

    task automatic clear_req();
        exc_valid = 1'b0; mret_req = 1'b0; wfi_req = 1'b0;
        irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0;
        flush_ack = 1'b0;
        exc_code = CW'($urandom);
        exc_tval = $urandom;
        pipe_pc = $urandom;
    endtask

    // Runs from the first FLUSH cycle through redirect and back to IDLE.
    task automatic flow(input logic is_mret, input logic [CW-1:0] cause, input logic is_int,
                        input logic [31:0] epc, input logic [31:0] tval, input int delay);
        int n = 0;
        bit seen = 0;
        int exp_n = (delay < T) ? delay + 1 : T;
        while (n < T + 4) begin
            flush_ack = (n >= delay);
            @(negedge clk);
            n++;
            if (trap_commit || mret_commit) begin
                seen = 1;
                break;
            end
        end
        flush_ack = 1'b0;
        if (delay >= T) err_exp = 1'b1;
        check("commit_seen", 32'(seen), 32'd1);
        check("commit_latency", n, exp_n);
        check("trap_commit", 32'(trap_commit), 32'(!is_mret));
        check("mret_commit", 32'(mret_commit), 32'(is_mret));
        check("timeout_err", 32'(timeout_err), 32'(err_exp));
        check("flush_req_commit", 32'(flush_req), 32'd0);
        if (!is_mret) begin
            check("trap_cause", 32'(trap_cause), 32'(cause));
            check("trap_is_int", 32'(trap_is_interrupt), 32'(is_int));
            check("trap_epc", trap_epc, epc);
            check("trap_tval", trap_tval, tval);
        end
        @(negedge clk);
        check("redirect", 32'(pc_redirect_valid), 32'd1);
        check("commit_one_cycle", 32'(trap_commit | mret_commit), 32'd0);
        check("stall_redirect", 32'(stall), 32'd1);
        @(negedge clk);
        check("redirect_one_cycle", 32'(pc_redirect_valid), 32'd0);
        check("stall_after", 32'(stall), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exc_valid = v.exc; exc_code = v.code; exc_tval = v.tval; pipe_pc = v.pc;
        {irq_meip, irq_mtip, irq_msip} = v.irq;
        csr_mie = v.mie; csr_mstatus_mie = v.gmie; mret_req = v.mret; wfi_req = v.wfi;
        flush_ack = 1'b0;
        #1;
        check("mip_out", mip_out, mip_of(v.irq));
        @(negedge clk);
        clear_req();
        case (v.kind)
            KNone: begin
                check("stall_none", 32'(stall), 32'd0);
                check("flush_none", 32'(flush_req), 32'd0);
            end
            KWait: begin
                check("stall_wait", 32'(stall), 32'd1);
                check("flush_wait", 32'(flush_req), 32'd0);
            end
            default: begin
                check("flush_req", 32'(flush_req), 32'd1);
                check("stall_flush", 32'(stall), 32'd1);
                flow(v.kind == KMret, v.cause, v.is_int, v.pc, v.etval, v.delay);
            end
        endcase
    endtask

    task automatic wake(input logic gmie, input logic [2:0] irq, input logic [31:0] mie,
                        input logic [31:0] pc);
        logic [CW-1:0] c = prio(mip_of(irq) & mie);
        csr_mstatus_mie = gmie; csr_mie = mie; pipe_pc = pc;
        {irq_meip, irq_mtip, irq_msip} = irq;
        @(negedge clk);
        clear_req();
        if (gmie) begin
            check("wake_flush", 32'(flush_req), 32'd1);
            flow(1'b0, c, 1'b1, pc, 32'd0, 2);
        end else begin
            check("wake_stall", 32'(stall), 32'd0);
            check("wake_flush_none", 32'(flush_req), 32'd0);
            @(negedge clk);
            check("wake_no_commit", 32'(trap_commit | mret_commit), 32'd0);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_flush"}, 32'(flush_req), 32'd0);
        check({name, "_stall"}, 32'(stall), 32'd0);
        check({name, "_commits"}, 32'(trap_commit | mret_commit | pc_redirect_valid), 32'd0);
        check({name, "_cause"}, 32'(trap_cause), 32'd0);
        check({name, "_int"}, 32'(trap_is_interrupt), 32'd0);
        check({name, "_epc"}, trap_epc, 32'd0);
        check({name, "_tval"}, trap_tval, 32'd0);
        check({name, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    vec_t tbl[10];

    initial begin
        //          exc code tval          pc           irq     mie    gm mr wf dly kind  cause int etval
        tbl[0] = mk(1, 2,  32'h0000_1234, 32'h100,     3'b000, 32'h0, 0, 0, 0, 1,  KTrap, 2,  0, 32'h1234);
        tbl[1] = mk(0, 0,  32'hdead_beef, 32'h200,     3'b111, 32'h888, 1, 0, 0, 0, KTrap, 11, 1, 32'h0);
        tbl[2] = mk(1, 5,  32'hdead_beef, 32'h204,     3'b111, 32'h888, 1, 0, 0, 0, KTrap, 5,  0, 32'hdead_beef);
        tbl[3] = mk(0, 0,  32'h0,         32'h208,     3'b011, 32'h888, 1, 1, 0, 3, KTrap, 3,  1, 32'h0);
        tbl[4] = mk(0, 0,  32'h0,         32'h20c,     3'b010, 32'h888, 1, 0, 1, 0, KTrap, 7,  1, 32'h0);
        tbl[5] = mk(0, 0,  32'h0,         32'h210,     3'b111, 32'h0,   1, 1, 0, 1, KMret, 0,  0, 32'h0);
        tbl[6] = mk(0, 0,  32'h0,         32'h214,     3'b100, 32'h800, 0, 0, 1, 0, KNone, 0,  0, 32'h0);
        tbl[7] = mk(0, 0,  32'h0,         32'h218,     3'b000, 32'h888, 1, 0, 0, 0, KNone, 0,  0, 32'h0);
        tbl[8] = mk(1, 13, 32'h55,        32'h21c,     3'b000, 32'h0,   0, 0, 0, T - 1, KTrap, 13, 0, 32'h55);
        tbl[9] = mk(1, 1,  32'h77,        32'h220,     3'b000, 32'h0,   0, 0, 0, 40, KTrap, 1,  0, 32'h77);

        #2;
        tag = 0;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            tag = 100 + i;
            run_vec(tbl[i]);
        end

        // WFI with interrupts enabled: park in WAIT, ignore exc/mret, wake into a timer trap.
        tag = 200;
        run_vec(mk(0, 0, 0, 32'h300, 3'b000, 32'h80, 1, 0, 1, 0, KWait, 0, 0, 0));
        exc_valid = 1'b1; mret_req = 1'b1;
        repeat (2) @(negedge clk);
        clear_req();
        check("wait_ignores_exc", 32'(stall), 32'd1);
        check("wait_no_flush", 32'(flush_req), 32'd0);
        wake(1'b1, 3'b010, 32'h80, 32'h304);

        // WFI with interrupts globally disabled: wake back to IDLE, no commit.
        tag = 201;
        run_vec(mk(0, 0, 0, 32'h400, 3'b000, 32'h80, 0, 0, 1, 0, KWait, 0, 0, 0));
        wake(1'b0, 3'b010, 32'h80, 32'h404);

        // Reset mid-FLUSH aborts the sequence and clears the sticky error.
        tag = 300;
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        exc_valid = 1'b1; exc_code = 4; exc_tval = 32'h99; pipe_pc = 32'h500;
        @(negedge clk);
        clear_req();
        repeat (4) @(negedge clk);
        check("midflush_flush", 32'(flush_req), 32'd1);
        rst_n = 1'b0;
        #1;
        err_exp = 1'b0;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        flush_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'(trap_commit | mret_commit | pc_redirect_valid | stall),
                  32'd0);
        end
        flush_ack = 1'b0;

        // Random transactions against the reference decision.
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            tag = 1000 + i;
            v.exc   = ($urandom_range(0, 3) == 0);
            v.code  = CW'($urandom);
            v.tval  = $urandom;
            v.pc    = $urandom;
            v.irq   = 3'($urandom);
            v.mie   = $urandom;
            v.gmie  = 1'($urandom);
            v.mret  = ($urandom_range(0, 2) == 0);
            v.wfi   = ($urandom_range(0, 2) == 0);
            v.delay = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 2)
                                                   : $urandom_range(0, 4);
            v = model(v);
            run_vec(v);
            if (v.kind == KWait) begin
                wake(1'($urandom), 3'($urandom_range(1, 7)), 32'h888, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
